// File: rtl/key_pio_pkg.sv
// Shared constants for the debounced key PIO: register word addresses and
// the idle level of an unpressed (active-low) key.
package key_pio_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_RAW  = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// One key lane: 2-flop synchronizer, stability counter and debounced flop.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce
  import key_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key,
  output logic o_sync,
  output logic o_deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= KEY_RELEASED;
      r_sync <= KEY_RELEASED;
      r_deb  <= KEY_RELEASED;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_key;
      r_sync <= r_meta;
      // any sample matching the accepted level restarts the count
      if (r_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_TC) begin
        r_deb <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sync = r_sync;
  assign o_deb  = r_deb;

endmodule

// File: rtl/key_debounce_pio.sv
// Avalon-MM key PIO with per-key debounce, interrupt mask and edge capture.
// Define KEY_PIO_BOTH_EDGES_EN to capture releases as well as presses.
module key_debounce_pio
  import key_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [WIDTH-1:0] r_deb_q;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;

  for (genvar g = 0; g < WIDTH; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk    (clk),
      .reset_n(reset_n),
      .i_key  (in_port[g]),
      .o_sync (w_sync[g]),
      .o_deb  (w_deb[g])
    );
  end

  if (WIDTH < 32) begin : g_wdata_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[31:WIDTH];
  end

  assign w_wr = chipselect & ~write_n;

`ifdef KEY_PIO_BOTH_EDGES_EN
  assign w_set = r_deb_q ^ w_deb;
`else
  assign w_set = r_deb_q & ~w_deb;
`endif

  assign w_clr = (w_wr && address == REG_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_q <= {WIDTH{KEY_RELEASED}};
      r_mask  <= '0;
      r_edge  <= '0;
    end else begin
      r_deb_q <= w_deb;
      if (w_wr && address == REG_MASK) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      // a new capture wins over a clear landing on the same bit
      r_edge <= (r_edge & ~w_clr) | w_set;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA: readdata[WIDTH-1:0] = w_deb;
      REG_RAW:  readdata[WIDTH-1:0] = w_sync;
      REG_MASK: readdata[WIDTH-1:0] = r_mask;
      REG_EDGE: readdata[WIDTH-1:0] = r_edge;
      default:  readdata = '0;
    endcase
  end

  assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_key_debounce_pio.sv
// Scoreboard bench for key_debounce_pio (WIDTH=4, DEBOUNCE_CYCLES=4).
// Reads push expected readdata/irq; a negedge monitor pops and compares.
module tb_key_debounce_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  string       name_q[$];
  logic [31:0] data_q[$];
  logic        irq_q[$];

  key_debounce_pio #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // each task occupies exactly one clock cycle, driven just after the posedge
  task automatic step_idle();
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic set_in(input logic [3:0] v);
    step_idle();
    in_port = v;
  endtask

  task automatic set_rst(input logic v);
    step_idle();
    reset_n = v;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [1:0] a,
                    input logic [31:0] exp_d, input logic exp_i);
    @(posedge clk); #1;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    name_q.push_back(nm);
    data_q.push_back(exp_d);
    irq_q.push_back(exp_i);
  endtask

  always @(negedge clk) begin
    if (chipselect && write_n) begin
      if (data_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h with no expected value queued", readdata);
      end else begin
        string       nm;
        logic [31:0] ed;
        logic        ei;
        nm = name_q.pop_front();
        ed = data_q.pop_front();
        ei = irq_q.pop_front();
        n_checks++;
        if (readdata !== ed) begin
          n_fail++;
          $display("FAIL %s readdata: got 0x%08h expected 0x%08h", nm, readdata, ed);
        end
        n_checks++;
        if (irq !== ei) begin
          n_fail++;
          $display("FAIL %s irq: got %0b expected %0b", nm, irq, ei);
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // reset state
    repeat (3) step_idle();
    set_rst(1'b1);
    rd("rst_data", 2'd0, 32'h0000_000F, 1'b0);
    rd("rst_raw",  2'd1, 32'h0000_000F, 1'b0);
    rd("rst_mask", 2'd2, 32'h0000_0000, 1'b0);
    rd("rst_edge", 2'd3, 32'h0000_0000, 1'b0);

    // key1 press: debounced after 6 edges, captured one edge later
    set_in(4'hD);
    repeat (4) step_idle();
    rd("k1_edge5_data", 2'd0, 32'h0000_000F, 1'b0);
    rd("k1_edge6_data", 2'd0, 32'h0000_000D, 1'b0);
    rd("k1_edge7_cap",  2'd3, 32'h0000_0002, 1'b0);
    rd("k1_raw",        2'd1, 32'h0000_000D, 1'b0);

    // key0 glitch of 3 cycles must be filtered out
    set_in(4'hC);
    step_idle();
    step_idle();
    set_in(4'hD);
    repeat (6) step_idle();
    rd("glitch_data", 2'd0, 32'h0000_000D, 1'b0);
    rd("glitch_edge", 2'd3, 32'h0000_0002, 1'b0);

    // mask raises irq on pending capture; data write ignored; W1C drops irq
    wr(2'd2, 32'h0000_0002);
    rd("mask_set",   2'd2, 32'h0000_0002, 1'b1);
    wr(2'd0, 32'h0000_0000);
    rd("data_ro",    2'd0, 32'h0000_000D, 1'b1);
    wr(2'd3, 32'h0000_0002);
    rd("w1c_bit1",   2'd3, 32'h0000_0000, 1'b0);

    // key3 then key2 one cycle later; W1C of bits 3,2 lands with bit2 set
    set_in(4'h5);
    set_in(4'h1);
    repeat (3) step_idle();
    rd("k3_edge5_data", 2'd0, 32'h0000_000D, 1'b0);
    rd("k3_edge6_data", 2'd0, 32'h0000_0005, 1'b0);
    wr(2'd3, 32'h0000_000C);
    rd("set_beats_clr", 2'd3, 32'h0000_0004, 1'b0);
    wr(2'd2, 32'h0000_0004);
    rd("mask_bit2",     2'd2, 32'h0000_0004, 1'b1);
    wr(2'd3, 32'h0000_0004);
    rd("w1c_bit2",      2'd3, 32'h0000_0000, 1'b0);

    // reset mid-count with all keys held low; full latency after release
    set_in(4'h0);
    repeat (3) step_idle();
    set_rst(1'b0);
    rd("inrst_data", 2'd0, 32'h0000_000F, 1'b0);
    rd("inrst_mask", 2'd2, 32'h0000_0000, 1'b0);
    set_rst(1'b1);
    repeat (4) step_idle();
    rd("post_rst_edge5", 2'd0, 32'h0000_000F, 1'b0);
    rd("post_rst_edge6", 2'd0, 32'h0000_0000, 1'b0);
    rd("post_rst_cap",   2'd3, 32'h0000_000F, 1'b0);

    step_idle();
    @(negedge clk);
    n_checks++;
    if (data_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected reads left, required 0", data_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
